// File: rtl/spectrogen_pkg.sv
// Shared types and defaults for the pulse_sequencer / pulsegen timebase.
package spectrogen_pkg;

    localparam int unsigned DEF_PRESET_W = 16;
    localparam int unsigned DEF_DIV_W    = 16;

    // Smallest step divider; keeps step low between strobes and apart from trigger.
    localparam int unsigned MIN_STEP_DIV = 2;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        TRIG,
        RUN
    } seq_state_t;

endpackage

// File: rtl/step_prescaler.sv
// D-cycle divider with synchronous clear; emits a registered terminal-count strobe.
module step_prescaler #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             clear,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    // Count 0..div-1; the strobe is registered one count early so it lands on the terminal cycle.
    always_ff @(posedge sysclk) begin
        if (reset || clear) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (run) begin
            cnt  <= (cnt == div - DIV_W'(1)) ? '0 : cnt + DIV_W'(1);
            tick <= (cnt == div - DIV_W'(2));
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/pulse_sequencer.sv
// Timebase and preset sequencer: step divider, per-slot step counter and preset table walk.
module pulse_sequencer
    import spectrogen_pkg::*;
#(
    parameter int unsigned N_SLOTS  = 8,
    parameter int unsigned SLOT_W   = 3,
    parameter int unsigned PRESET_W = DEF_PRESET_W,
    parameter int unsigned DIV_W    = DEF_DIV_W
) (
    input  logic                sysclk,
    input  logic                reset,
    input  logic                enable,
    input  logic [DIV_W-1:0]    step_div,
    input  logic [DIV_W-1:0]    period,
    input  logic [SLOT_W:0]     num_slots,
    input  logic                wr_en,
    input  logic [SLOT_W-1:0]   wr_addr,
    input  logic [PRESET_W-1:0] wr_data,
    output logic                step,
    output logic                trigger,
    output logic [PRESET_W-1:0] preset,
    output logic [SLOT_W-1:0]   slot,
    output logic                sweep_done,
    output logic                running
);

    seq_state_t state, next_state;

    logic [PRESET_W-1:0] slot_table [N_SLOTS];

    logic [DIV_W-1:0]  div_eff, per_eff;
    logic [DIV_W-1:0]  div_q, per_q;
    logic [DIV_W-1:0]  step_cnt;
    logic [SLOT_W:0]   num_eff;
    logic [SLOT_W-1:0] slot_idx;
    logic              tick;
    logic              last_step;
    logic              last_slot;

    // Clamp the live configuration inputs and decode the end-of-slot / end-of-sweep conditions.
    always_comb begin
        div_eff = (step_div < DIV_W'(MIN_STEP_DIV)) ? DIV_W'(MIN_STEP_DIV) : step_div;
        per_eff = (period == '0) ? DIV_W'(1) : period;
        if (num_slots == '0)
            num_eff = (SLOT_W+1)'(1);
        else if (num_slots > (SLOT_W+1)'(N_SLOTS))
            num_eff = (SLOT_W+1)'(N_SLOTS);
        else
            num_eff = num_slots;
        last_step = (state == RUN) && tick && (step_cnt == per_q - DIV_W'(1));
        // ">=" rather than "==" so a shrunken num_slots still wraps at the next advance.
        last_slot = ({1'b0, slot_idx} + (SLOT_W+1)'(1)) >= num_eff;
    end

    // State register.
    always_ff @(posedge sysclk) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state logic; dropping enable returns to IDLE from any state.
    always_comb begin
        next_state = state;
        if (!enable) begin
            next_state = IDLE;
        end else begin
            unique case (state)
                IDLE: next_state = LOAD;
                LOAD: next_state = TRIG;
                TRIG: next_state = RUN;
                RUN:  if (last_step) next_state = LOAD;
                default: next_state = IDLE;
            endcase
        end
    end

    // Output decode; trigger and running come straight off the state register.
    always_comb begin
        trigger    = (state == TRIG);
        running    = (state != IDLE);
        step       = tick;
        sweep_done = last_step && last_slot;
    end

    step_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .sysclk (sysclk),
        .reset  (reset),
        .clear  (state != RUN),
        .run    ((state == RUN) && enable),
        .div    (div_q),
        .tick   (tick)
    );

    // Count steps within the current slot.
    always_ff @(posedge sysclk) begin
        if (reset || state != RUN)
            step_cnt <= '0;
        else if (tick)
            step_cnt <= step_cnt + DIV_W'(1);
    end

    // Slot walk and LOAD capture; slot_idx leads and the visible slot follows it together with preset.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            slot_idx <= '0;
            slot     <= '0;
            preset   <= '0;
            div_q    <= '0;
            per_q    <= '0;
        end else if (!enable) begin
            slot_idx <= '0;
            slot     <= '0;
        end else begin
            if (state == LOAD) begin
                preset <= slot_table[slot_idx];
                slot   <= slot_idx;
                div_q  <= div_eff;
                per_q  <= per_eff;
            end
            if (last_step)
                slot_idx <= last_slot ? '0 : slot_idx + SLOT_W'(1);
        end
    end

    // Preset table; a write coincident with LOAD of the same entry is seen next time round.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_SLOTS; i++)
                slot_table[i] <= '0;
        end else if (wr_en) begin
            slot_table[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_pulse_sequencer.sv
// Directed bench for pulse_sequencer with hand-computed expected timing.
module tb_pulse_sequencer;

    logic        sysclk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] step_div;
    logic [15:0] period;
    logic [3:0]  num_slots;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        step;
    logic        trigger;
    logic [15:0] preset;
    logic [2:0]  slot;
    logic        sweep_done;
    logic        running;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    pulse_sequencer #(
        .N_SLOTS  (8),
        .SLOT_W   (3),
        .PRESET_W (16),
        .DIV_W    (16)
    ) dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .enable     (enable),
        .step_div   (step_div),
        .period     (period),
        .num_slots  (num_slots),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .step       (step),
        .trigger    (trigger),
        .preset     (preset),
        .slot       (slot),
        .sweep_done (sweep_done),
        .running    (running)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic wait_clk();
        @(posedge sysclk);
        #1;
    endtask

    task automatic wr(input logic [2:0] addr, input logic [15:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        wait_clk();
        wr_en   = 1'b0;
    endtask

    // Entered in a trigger cycle; checks a whole slot and returns in the next trigger cycle.
    task automatic check_slot(input int unsigned d, input int unsigned p,
                              input int unsigned exp_preset, input int unsigned exp_slot,
                              input bit exp_sweep);
        check("trig_on", 32'(trigger), 32'd1);
        check("preset", 32'(preset), 32'(exp_preset));
        check("slot", 32'(slot), 32'(exp_slot));
        check("step_at_trig", 32'(step), 32'd0);
        for (int unsigned k = 1; k <= p * d; k++) begin
            wait_clk();
            check("step", 32'(step), 32'(k % d == 0));
            check("trig_off", 32'(trigger), 32'd0);
            check("sweep", 32'(sweep_done), 32'(exp_sweep && k == p * d));
        end
        wait_clk();
        check("load_step", 32'(step), 32'd0);
        check("load_trig", 32'(trigger), 32'd0);
        check("load_running", 32'(running), 32'd1);
        wait_clk();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_step"}, 32'(step), 32'd0);
        check({tag, "_trig"}, 32'(trigger), 32'd0);
        check({tag, "_sweep"}, 32'(sweep_done), 32'd0);
        check({tag, "_running"}, 32'(running), 32'd0);
        check({tag, "_preset"}, 32'(preset), 32'd0);
        check({tag, "_slot"}, 32'(slot), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        step_div  = 16'd4;
        period    = 16'd3;
        num_slots = 4'd2;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        wait_clk();
        wait_clk();
        check_zero_outputs("reset");
        reset = 1'b0;
        wr(3'd0, 16'd5);
        wr(3'd1, 16'd9);

        // D=4, P=3, two slots
        enable = 1'b1;
        wait_clk();
        check("first_load_running", 32'(running), 32'd1);
        check("first_load_trig", 32'(trigger), 32'd0);
        wait_clk();
        check_slot(4, 3, 5, 0, 0);
        check_slot(4, 3, 9, 1, 1);
        check_slot(4, 3, 5, 0, 0);

        // enable dropped mid-RUN of slot 1
        repeat (5) wait_clk();
        enable = 1'b0;
        wait_clk();
        check("dis_running", 32'(running), 32'd0);
        check("dis_slot", 32'(slot), 32'd0);
        check("dis_preset_hold", 32'(preset), 32'd9);
        for (int i = 0; i < 6; i++) begin
            check("dis_step", 32'(step), 32'd0);
            check("dis_trig", 32'(trigger), 32'd0);
            wait_clk();
        end
        enable = 1'b1;
        wait_clk();
        wait_clk();
        check_slot(4, 3, 5, 0, 0);
        enable = 1'b0;
        wait_clk();

        // step_div=0, period=0 behaves as D=2, P=1
        step_div  = 16'd0;
        period    = 16'd0;
        num_slots = 4'd1;
        enable    = 1'b1;
        wait_clk();
        wait_clk();
        repeat (3) check_slot(2, 1, 5, 0, 1);
        enable = 1'b0;
        wait_clk();

        // write to slot 1 during its LOAD cycle
        num_slots = 4'd2;
        enable    = 1'b1;
        wait_clk();
        wait_clk();
        check("wr_trig0", 32'(trigger), 32'd1);
        wait_clk();
        wait_clk();
        wait_clk();
        check("wr_in_load_trig", 32'(trigger), 32'd0);
        check("wr_in_load_running", 32'(running), 32'd1);
        wr(3'd1, 16'h00AA);
        check_slot(2, 1, 9, 1, 1);
        check_slot(2, 1, 5, 0, 0);
        check_slot(2, 1, 16'h00AA, 1, 1);

        // synchronous reset pulse mid-RUN
        wait_clk();
        wait_clk();
        reset = 1'b1;
        wait_clk();
        check_zero_outputs("midrun_reset");
        reset = 1'b0;
        wait_clk();
        wait_clk();
        check_slot(2, 1, 0, 0, 0);
        check_slot(2, 1, 0, 1, 1);
        enable = 1'b0;
        wait_clk();

        // all eight slots, then num_slots=0
        for (int i = 0; i < 8; i++)
            wr(3'(i), 16'(16 + i));
        num_slots = 4'd8;
        enable    = 1'b1;
        wait_clk();
        wait_clk();
        for (int unsigned i = 0; i < 8; i++)
            check_slot(2, 1, 16 + i, i, i == 7);
        check_slot(2, 1, 16, 0, 0);
        enable = 1'b0;
        wait_clk();
        num_slots = 4'd0;
        enable    = 1'b1;
        wait_clk();
        wait_clk();
        repeat (3) check_slot(2, 1, 16, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
